// File: rtl/if_pc_ctrl_pkg.sv
// Shared types and width helpers for the IF-stage fetch PC controller.
package if_pkg;

    function automatic int irq_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lvl_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int XLEN_DEF    = 32;
    localparam int NUM_IRQ_DEF = 4;
    localparam int IRQ_W       = irq_w(NUM_IRQ_DEF);
    localparam int LVL_W       = lvl_w(NUM_IRQ_DEF);

    // Stack entry layout for the default configuration; the top builds the
    // same {ret_addr, level} shape at its own parameter widths.
    typedef struct packed {
        logic [XLEN_DEF-1:0] ret_addr;
        logic [LVL_W-1:0]    level;
    } stack_entry_t;

    typedef enum logic [2:0] {
        SRC_BOOT, SRC_UNDO, SRC_PCR, SRC_RETI,
        SRC_IRQ,  SRC_HOLD, SRC_PRED, SRC_SEQ
    } src_t;

endpackage

// File: rtl/if_pc_ctrl_if.sv
// Fetch-control bus between the pipeline/interrupt fabric and if_pc_ctrl.
interface if_pc_ctrl_if
    import if_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4
);
    localparam int IW = irq_w(NUM_IRQ);
    localparam int LW = lvl_w(NUM_IRQ);

    logic [NUM_IRQ-1:0] irq;
    logic               stall;
    logic               branch_predict;
    logic [XLEN-1:0]    branch_pc;
    logic               branch_undo;
    logic [XLEN-1:0]    pc_not_taken;
    logic               pcr_take;
    logic [XLEN-1:0]    pcr;
    logic               reti;
    logic [XLEN-1:0]    mem_addr;
    logic [XLEN-1:0]    pc_plus_4;
    logic               irq_taken;
    logic [IW-1:0]      irq_id;
    logic [LW-1:0]      irq_level;
    logic               stack_full;
    logic               stack_err;

    modport master (
        output irq, stall, branch_predict, branch_pc, branch_undo,
               pc_not_taken, pcr_take, pcr, reti,
        input  mem_addr, pc_plus_4, irq_taken, irq_id, irq_level,
               stack_full, stack_err
    );

    modport slave (
        input  irq, stall, branch_predict, branch_pc, branch_undo,
               pc_not_taken, pcr_take, pcr, reti,
        output mem_addr, pc_plus_4, irq_taken, irq_id, irq_level,
               stack_full, stack_err
    );
endinterface

// File: rtl/if_pc_ctrl_irq_nest_stack.sv
// LIFO of interrupt return contexts; push and pop are never requested together.
module irq_nest_stack #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [SPW-1:0]          sp;
    logic [AW-1:0]           top_idx;

    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = AW'(sp - SPW'(1));
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp  <= '0;
            mem <= '0;
        end else if (push && !full) begin
            mem[AW'(sp)] <= din;
            sp           <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end
endmodule

// File: rtl/if_pc_ctrl.sv
// IF-stage next-PC selection with prioritised, nestable vectored interrupts.
module if_pc_ctrl
    import if_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              NUM_IRQ    = 4,
    parameter logic [XLEN-1:0] VEC_BASE   = 'h100,
    parameter int              VEC_STRIDE = 16,
    parameter int              NEST_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    if_pc_ctrl_if.slave  bus
);
    localparam int IW = irq_w(NUM_IRQ);
    localparam int LW = lvl_w(NUM_IRQ);
    localparam int EW = XLEN + LW;

    typedef struct packed {
        logic [XLEN-1:0] ret_addr;
        logic [LW-1:0]   level;
    } ent_t;

    logic [XLEN-1:0]    pc, next_pc, pc_p4, vec_addr;
    logic               boot;
    logic [NUM_IRQ-1:0] pending, irq_q, elig, take_mask;
    logic [LW-1:0]      cur_level;
    logic [IW-1:0]      win;
    logic               irq_hit, irq_ok, reti_eff;
    logic               push, pop, full, empty;
    logic [EW-1:0]      top_raw;
    ent_t               push_ent, top_ent;
    src_t               src;

    assign pc_p4    = pc + XLEN'(4);
    assign vec_addr = VEC_BASE + XLEN'(win) * XLEN'(VEC_STRIDE);
    assign top_ent  = ent_t'(top_raw);
    assign push_ent = '{ret_addr: pc_p4, level: cur_level};

    // reti only counts when no higher-priority redirect owns this cycle
    assign reti_eff = bus.reti & ~boot & ~bus.branch_undo & ~bus.pcr_take;
    assign irq_ok   = ~boot & ~full & ~bus.stall & ~bus.branch_undo
                    & ~bus.pcr_take & ~bus.reti;

    always_comb begin
        elig    = '0;
        win     = '0;
        irq_hit = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++)
            elig[i] = pending[i] && (LW'(i) < cur_level);
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                irq_hit = irq_ok;
                win     = IW'(i);
            end
        end
    end

    always_comb begin
        src = SRC_SEQ;
        if (boot)                         src = SRC_BOOT;
        else if (bus.branch_undo)         src = SRC_UNDO;
        else if (bus.pcr_take)            src = SRC_PCR;
        else if (reti_eff && !empty)      src = SRC_RETI;
        else if (irq_hit)                 src = SRC_IRQ;
        else if (bus.stall)               src = SRC_HOLD;
        else if (bus.branch_predict)      src = SRC_PRED;
    end

    always_comb begin
        next_pc = pc_p4;
        case (src)
            SRC_BOOT: next_pc = RESET_PC;
            SRC_UNDO: next_pc = bus.pc_not_taken;
            SRC_PCR:  next_pc = bus.pcr;
            SRC_RETI: next_pc = top_ent.ret_addr;
            SRC_IRQ:  next_pc = vec_addr;
            SRC_HOLD: next_pc = pc;
            SRC_PRED: next_pc = bus.branch_pc;
            default:  next_pc = pc_p4;
        endcase
    end

    assign push      = (src == SRC_IRQ);
    assign pop       = (src == SRC_RETI);
    assign take_mask = push ? (NUM_IRQ'(1) << win) : '0;

    irq_nest_stack #(.W(EW), .DEPTH(NEST_DEPTH)) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_ent),
        .top   (top_raw),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            boot      <= 1'b1;
            irq_q     <= '0;
            pending   <= '0;
            cur_level <= LW'(NUM_IRQ);
        end else begin
            pc      <= next_pc;
            boot    <= 1'b0;
            irq_q   <= bus.irq;
            // a fresh edge wins over the clear of the channel being entered
            pending <= (pending & ~take_mask) | (bus.irq & ~irq_q);
            if (push)     cur_level <= LW'(win);
            else if (pop) cur_level <= top_ent.level;
        end
    end

    assign bus.mem_addr   = next_pc;
    assign bus.pc_plus_4  = pc_p4;
    assign bus.irq_taken  = push;
    assign bus.irq_id     = push ? win : '0;
    assign bus.irq_level  = cur_level;
    assign bus.stack_full = full;
    assign bus.stack_err  = reti_eff & empty;
endmodule
